video_bank_sys: RTL and testbench
=================================

// Module: video_bank_sys
// PURPOSE
//  Generates clock enables from CLK_40 and implements a double-buffered 1-bit video frame store.
//  - Serial video bits (MISO) fill the write bank at the SPI rate.
//  - The read bank is scanned at full screen resolution; each stored bit is replicated SCALE x SCALE.
//  - Sits between the SPI/SD-card reader and the display pixel pipeline.
// PARAMETERS
//  SCREEN_WIDTH   32   displayed pixels per line
//  SCREEN_HEIGHT  24   displayed lines per frame
//  SCALE          4    upscale factor; bank holds (SCREEN_WIDTH/SCALE)*(SCREEN_HEIGHT/SCALE) bits
//  PIXEL_DIV      4    CLK_40 cycles per read_pixel_clk_en pulse
//  SPI_DIV        40   CLK_40 cycles per SPI_clk_en pulse (1 MHz)
//  AUDIO_DIV      907  CLK_40 cycles per audio_clk_en pulse (~44.1 kHz)
// PORTS
//  CLK_40             in   1  40 MHz system clock
//  reset              in   1  asynchronous, active-low reset
//  video_bank_we      in   1  write enable; when low, writes pause and the write address holds
//  MISO               in   1  serial video bit, sampled on SPI_clk_en
//  read_pixel_clk_en  out  1  one-cycle pixel enable
//  SPI_clk_en         out  1  one-cycle SPI enable
//  audio_clk_en       out  1  one-cycle audio enable
//  video_bank_sel     out  1  0: bank0 is read and bank1 is written; 1: the reverse
//  pixel_data_out     out  1  current pixel
// BEHAVIOUR
//  Reset and divider enables
//  - Reset (async assert, sync deassert use): all counters 0; all enables 0; video_bank_sel=0;
//    pixel_data_out=0; wr_full=0; valid=0.
//  - Bank RAM contents are not cleared by reset.
//  - Each divider counts 0..DIV-1; its enable is high for exactly the cycle where count==DIV-1.
//  - First pulses after reset release: SPI at cycle 40, pixel at cycle 4, audio at cycle 907.
//  Write path
//  - Condition: SPI_clk_en && video_bank_we && !wr_full.
//  - Action: bank[~sel][wr_addr] <= MISO; wr_addr++.
//  - Address order: raster, x fastest, address = y*X_W + x.
//  - When wr_addr reaches DEPTH-1 and is written, set wr_full. Further MISO bits are ignored until swap.
//  Read path
//  - On read_pixel_clk_en, register pixel_data_out <= valid ? bank[sel][(y/SCALE)*X_W + x/SCALE] : 0.
//  - Latency: 1 cycle after the enable.
//  - Then x++. x wraps at SCREEN_WIDTH with y++; y wraps at SCREEN_HEIGHT (frame end).
//  Bank swap
//  - At frame end, if wr_full (including a wr_full set in the same cycle):
//    toggle video_bank_sel; clear wr_full; wr_addr=0; valid=1.
//  - Otherwise keep the banks and replay the same read bank.
//  - The swap never occurs mid-frame.
//  Other rules
//  - Enables coincide freely; the write and read paths are independent within a cycle.
//  - Reset mid-frame aborts the partial write; the restarted fill begins at address 0.
// CONFIGURATION
//  VIDEO_TEST_PATTERN_EN
//  - Defined: pixel_data_out = (x/SCALE ^ y/SCALE) & 1 (checkerboard), regardless of bank contents or valid.
//    The write path and swap logic are unchanged.
//  - Undefined: normal bank output as above.
// TESTING
//  1. Reset low then high; count CLK_40 cycles -> SPI_clk_en every 40, pixel every 4, audio every 907;
//     each enable is exactly 1 cycle wide.
//  2. we=1, MISO alternating 1,0 -> after 48 SPI enables wr_full=1; at the next frame end (cycle 3072)
//     video_bank_sel flips to 1; the next frame shows vertical 4-px stripes (1,1,1,1,0,0,0,0...).
//  3. Before the first swap -> pixel_data_out stays 0.
//  4. we=0 for 10 SPI enables mid-fill -> wr_addr holds; the swap is delayed by one frame
//     when the fill completes after frame end.
//  5. Write completes in the same cycle as frame end -> the swap happens in that frame.
//  6. Assert reset mid-frame -> all outputs return to reset values immediately; video_bank_sel=0.

Source files
------------

// File: rtl/video_bank_sys_if.sv
// Serial-in / pixel-out signal bundle for the double-buffered video frame store.
interface video_bank_sys_if;
  logic video_bank_we;
  logic MISO;
  logic read_pixel_clk_en;
  logic SPI_clk_en;
  logic audio_clk_en;
  logic video_bank_sel;
  logic pixel_data_out;

  modport master (
    output video_bank_we, MISO,
    input  read_pixel_clk_en, SPI_clk_en, audio_clk_en, video_bank_sel, pixel_data_out
  );

  modport slave (
    input  video_bank_we, MISO,
    output read_pixel_clk_en, SPI_clk_en, audio_clk_en, video_bank_sel, pixel_data_out
  );
endinterface

// File: rtl/video_bank_sys.sv
// Clock-enable dividers plus a double-buffered 1-bit frame store, upscaled SCALE x SCALE on readout.
// Define VIDEO_TEST_PATTERN_EN to replace the bank output with a cell checkerboard.
module video_bank_sys #(
  parameter int SCREEN_WIDTH  = 32,
  parameter int SCREEN_HEIGHT = 24,
  parameter int SCALE         = 4,
  parameter int PIXEL_DIV     = 4,
  parameter int SPI_DIV       = 40,
  parameter int AUDIO_DIV     = 907
) (
  input  logic       CLK_40,
  input  logic       reset,
  video_bank_sys_if.slave bus
);

  localparam int X_W    = SCREEN_WIDTH / SCALE;
  localparam int Y_H    = SCREEN_HEIGHT / SCALE;
  localparam int DEPTH  = X_W * Y_H;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int X_BITS = $clog2(SCREEN_WIDTH);
  localparam int Y_BITS = $clog2(SCREEN_HEIGHT);
  localparam int PIX_W  = $clog2(PIXEL_DIV);
  localparam int SPI_W  = $clog2(SPI_DIV);
  localparam int AUD_W  = $clog2(AUDIO_DIV);

  logic [PIX_W-1:0]  pixCnt_q, pixCnt_d;
  logic [SPI_W-1:0]  spiCnt_q, spiCnt_d;
  logic [AUD_W-1:0]  audCnt_q, audCnt_d;
  logic [X_BITS-1:0] xPos_q, xPos_d;
  logic [Y_BITS-1:0] yPos_q, yPos_d;
  logic [ADDR_W-1:0] wrAddr_q, wrAddr_d;
  logic              wrFull_q, wrFull_d;
  logic              valid_q, valid_d;
  logic              sel_q, sel_d;
  logic              pixel_q, pixel_d;

  logic bank0_q [DEPTH];
  logic bank1_q [DEPTH];

  logic pixEn, spiEn, audEn;
  logic wrFire, wrLast, frameEnd, swap;
  logic lastX, lastY;
  logic [X_BITS-1:0] xCell;
  logic [Y_BITS-1:0] yCell;
  logic [ADDR_W-1:0] rdAddr;
  logic readBit;

  assign pixEn = (pixCnt_q == PIX_W'(PIXEL_DIV - 1));
  assign spiEn = (spiCnt_q == SPI_W'(SPI_DIV - 1));
  assign audEn = (audCnt_q == AUD_W'(AUDIO_DIV - 1));

  assign lastX    = (xPos_q == X_BITS'(SCREEN_WIDTH - 1));
  assign lastY    = (yPos_q == Y_BITS'(SCREEN_HEIGHT - 1));
  assign frameEnd = pixEn && lastX && lastY;

  // A write landing on the last address in the frame-end cycle still counts as a full bank.
  assign wrFire = spiEn && bus.video_bank_we && !wrFull_q;
  assign wrLast = wrFire && (wrAddr_q == ADDR_W'(DEPTH - 1));
  assign swap   = frameEnd && (wrFull_q || wrLast);

  assign xCell   = X_BITS'(int'(xPos_q) / SCALE);
  assign yCell   = Y_BITS'(int'(yPos_q) / SCALE);
  assign rdAddr  = ADDR_W'(int'(yCell) * X_W + int'(xCell));
  assign readBit = sel_q ? bank1_q[rdAddr] : bank0_q[rdAddr];

  always_comb begin
    pixCnt_d = pixEn ? '0 : pixCnt_q + 1'b1;
    spiCnt_d = spiEn ? '0 : spiCnt_q + 1'b1;
    audCnt_d = audEn ? '0 : audCnt_q + 1'b1;

    xPos_d = xPos_q;
    yPos_d = yPos_q;
    if (pixEn) begin
      if (lastX) begin
        xPos_d = '0;
        yPos_d = lastY ? '0 : yPos_q + 1'b1;
      end else begin
        xPos_d = xPos_q + 1'b1;
      end
    end

    wrAddr_d = wrAddr_q;
    wrFull_d = wrFull_q;
    if (swap) begin
      wrAddr_d = '0;
      wrFull_d = 1'b0;
    end else if (wrLast) begin
      wrFull_d = 1'b1;
    end else if (wrFire) begin
      wrAddr_d = wrAddr_q + 1'b1;
    end

    sel_d   = sel_q ^ swap;
    valid_d = valid_q | swap;

    pixel_d = pixel_q;
    if (pixEn) begin
`ifdef VIDEO_TEST_PATTERN_EN
      pixel_d = xCell[0] ^ yCell[0];
`else
      pixel_d = valid_q ? readBit : 1'b0;
`endif
    end
  end

  always_ff @(posedge CLK_40 or negedge reset) begin
    if (!reset) begin
      pixCnt_q <= '0;
      spiCnt_q <= '0;
      audCnt_q <= '0;
      xPos_q   <= '0;
      yPos_q   <= '0;
      wrAddr_q <= '0;
      wrFull_q <= 1'b0;
      valid_q  <= 1'b0;
      sel_q    <= 1'b0;
      pixel_q  <= 1'b0;
    end else begin
      pixCnt_q <= pixCnt_d;
      spiCnt_q <= spiCnt_d;
      audCnt_q <= audCnt_d;
      xPos_q   <= xPos_d;
      yPos_q   <= yPos_d;
      wrAddr_q <= wrAddr_d;
      wrFull_q <= wrFull_d;
      valid_q  <= valid_d;
      sel_q    <= sel_d;
      pixel_q  <= pixel_d;
    end
  end

  // Bank storage survives reset; the write bank is always the one not being displayed.
  always_ff @(posedge CLK_40) begin
    if (wrFire) begin
      if (sel_q) begin
        bank0_q[wrAddr_q] <= bus.MISO;
      end else begin
        bank1_q[wrAddr_q] <= bus.MISO;
      end
    end
  end

  assign bus.read_pixel_clk_en = pixEn;
  assign bus.SPI_clk_en        = spiEn;
  assign bus.audio_clk_en      = audEn;
  assign bus.video_bank_sel    = sel_q;
  assign bus.pixel_data_out    = pixel_q;

endmodule

// File: tb/tb_video_bank_sys.sv
// Randomized scoreboard bench for video_bank_sys against a frame-level reference model.
module tb_video_bank_sys;

  localparam int SW        = 32;
  localparam int SH        = 24;
  localparam int SC        = 4;
  localparam int XW        = SW / SC;
  localparam int DEPTH     = (SW / SC) * (SH / SC);
  localparam int FRAME_PIX = SW * SH;

  logic CLK_40 = 1'b0;
  logic reset  = 1'b0;

  video_bank_sys_if bus();

  video_bank_sys dut (
    .CLK_40(CLK_40),
    .reset (reset),
    .bus   (bus)
  );

  always #5 CLK_40 = ~CLK_40;

  int passCount  = 0;
  int checkCount = 0;

  int k;
  int filled;
  bit validM;
  bit selM;
  bit pend [DEPTH];
  bit disp [DEPTH];
  bit expQ [$];
  bit prevEn;

  task automatic checkOutput(input string name, input logic actual, input logic expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s at k=%0d: actual=%0b required=%0b", name, k, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int phase, input int kk);
    if (phase == 1) begin
      if (kk < 3072) begin
        bus.video_bank_we = 1'b1;
        bus.MISO          = ((kk / 40) % 2) == 0;
      end else if (kk < 9216) begin
        bus.video_bank_we = ($urandom_range(0, 3) != 0);
        bus.MISO          = 1'($urandom_range(0, 1));
      end else if (kk < 12288) begin
        bus.video_bank_we = 1'b1;
        bus.MISO          = 1'($urandom_range(0, 1));
      end else if (kk < 13479) begin
        bus.video_bank_we = 1'b0;
        bus.MISO          = 1'($urandom_range(0, 1));
      end else if (kk < 15360) begin
        bus.video_bank_we = 1'b1;
        bus.MISO          = 1'($urandom_range(0, 1));
      end else begin
        bus.video_bank_we = 1'b0;
        bus.MISO          = 1'($urandom_range(0, 1));
      end
    end else begin
      bus.video_bank_we = !(kk >= 800 && kk < 2400);
      bus.MISO          = ((kk / 40) % 2) == 0;
    end
  endtask

  task automatic checkResetOutputs();
    checkOutput("rst_pixel", bus.pixel_data_out, 1'b0);
    checkOutput("rst_sel",   bus.video_bank_sel, 1'b0);
    checkOutput("rst_spi",   bus.SPI_clk_en, 1'b0);
    checkOutput("rst_pix",   bus.read_pixel_clk_en, 1'b0);
    checkOutput("rst_audio", bus.audio_clk_en, 1'b0);
  endtask

  // Reference model: enables from cycle arithmetic, the displayed image is the last full batch of bits.
  always @(negedge CLK_40) begin
    if (!reset) begin
      k      = 0;
      filled = 0;
      validM = 1'b0;
      selM   = 1'b0;
      expQ.delete();
    end else begin
      bit spiE, pixE, audE, expBit;
      int idx, x, y;
      spiE = (k % 40) == 39;
      pixE = (k % 4) == 3;
      audE = (k % 907) == 906;
      idx  = (k / 4) % FRAME_PIX;
      checkOutput("spi_en",   bus.SPI_clk_en, spiE);
      checkOutput("pixel_en", bus.read_pixel_clk_en, pixE);
      checkOutput("audio_en", bus.audio_clk_en, audE);
      checkOutput("bank_sel", bus.video_bank_sel, selM);
      if (pixE) begin
        x = idx % SW;
        y = idx / SW;
`ifdef VIDEO_TEST_PATTERN_EN
        expBit = 1'(((x / SC) ^ (y / SC)) & 1);
`else
        expBit = validM ? disp[(y / SC) * XW + x / SC] : 1'b0;
`endif
        expQ.push_back(expBit);
      end
      if (spiE && bus.video_bank_we && filled < DEPTH) begin
        pend[filled] = bus.MISO;
        filled++;
      end
      if (pixE && idx == FRAME_PIX - 1 && filled == DEPTH) begin
        disp   = pend;
        filled = 0;
        validM = 1'b1;
        selM   = !selM;
      end
      k++;
    end
  end

  // Monitor: one cycle after the DUT pulses its pixel enable, the registered pixel is compared.
  always @(negedge CLK_40) begin
    if (!reset) begin
      prevEn = 1'b0;
    end else begin
      if (prevEn) begin
        if (expQ.size() == 0) begin
          checkCount++;
          $display("[TB] FAIL pixel_pop at k=%0d: actual=%0b required=<no expected pixel>", k, bus.pixel_data_out);
        end else begin
          checkOutput("pixel_data", bus.pixel_data_out, expQ.pop_front());
        end
      end
      prevEn = bus.read_pixel_clk_en;
    end
  end

  initial begin
    bus.video_bank_we = 1'b0;
    bus.MISO          = 1'b0;
    reset             = 1'b0;
    repeat (3) @(posedge CLK_40);
    #1;
    checkResetOutputs();
    reset = 1'b1;
    applyStimulus(1, 0);
    for (int s = 1; s < 17000; s++) begin
      @(posedge CLK_40);
      #1;
      applyStimulus(1, s);
    end

    @(posedge CLK_40);
    #3;
    reset = 1'b0;
    #1;
    checkResetOutputs();
    repeat (3) @(posedge CLK_40);
    #1;
    reset = 1'b1;
    applyStimulus(2, 0);
    for (int s = 1; s < 7000; s++) begin
      @(posedge CLK_40);
      #1;
      applyStimulus(2, s);
    end

    @(posedge CLK_40);
    #1;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
